decomp_addr_ctrl: RTL and testbench

Control stage directly upstream of the decompressor pipeline register. Sequences one image decompression:
- accepts a 64-entry RGB codebook from a valid/ready stream and issues the codebook write signals (weight_*);
- then sweeps the per-pixel index memory, issuing the codebook read index (tag_*) and the output-image write address and enable (RAM3_*).

All outputs feed the pipeline register unchanged, one cycle ahead of the codebook/RAM3 stage.

---
 rtl/decomp_addr_ctrl.sv | 122 ++++++++++++
 tb/tb_decomp_addr_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decomp_addr_ctrl.sv
// Address/control sequencer for one image decompression: codebook load, then index sweep.
// Optional macro DECOMP_PAUSE_EN adds a pause input that stalls the DECODE index sweep.
module decomp_addr_ctrl #(
    parameter int unsigned DATA_W  = 24,
    parameter int unsigned CB_AW   = 6,
    parameter int unsigned PIX_AW  = 20,
    parameter int unsigned PIX_NUM = 1048576
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
`ifdef DECOMP_PAUSE_EN
    input  logic              pause,
`endif
    input  logic              cb_valid,
    input  logic [DATA_W-1:0] cb_data,
    output logic              cb_ready,
    output logic              idx_re,
    output logic [PIX_AW-1:0] idx_A,
    input  logic [CB_AW-1:0]  idx_data,
    output logic              weight_en,
    output logic [DATA_W-1:0] weight_data,
    output logic [CB_AW-1:0]  weight_A,
    output logic              tag_en,
    output logic [CB_AW-1:0]  tag_A,
    output logic              RAM3_WE_reg_out,
    output logic [PIX_AW-1:0] RAM3_A_reg_out,
    output logic [1:0]        state,
    output logic              done
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StLoadCb = 2'd1,
        StDecode = 2'd2,
        StDone   = 2'd3
    } state_e;

    localparam logic [CB_AW-1:0]  CbLast  = {CB_AW{1'b1}};
    localparam logic [PIX_AW-1:0] PixLast = PIX_AW'(PIX_NUM - 1);

    state_e            state_q, state_d;
    logic [CB_AW-1:0]  cb_cnt_q, cb_cnt_d;
    logic [PIX_AW-1:0] pix_cnt_q, pix_cnt_d;
    logic              stall;
    logic              accept;

`ifdef DECOMP_PAUSE_EN
    assign stall = pause;
`else
    assign stall = 1'b0;
`endif

    always_comb begin
        cb_ready        = (state_q == StLoadCb);
        accept          = cb_ready & cb_valid;
        idx_re          = (state_q == StDecode) & ~stall;
        idx_A           = pix_cnt_q;
        done            = (state_q == StDone);
        state           = state_q;
        RAM3_WE_reg_out = tag_en;
        // Read data belongs to the pixel addressed last cycle, matching RAM3_A_reg_out.
        tag_A           = tag_en ? idx_data : '0;
    end

    always_comb begin
        state_d   = state_q;
        cb_cnt_d  = cb_cnt_q;
        pix_cnt_d = pix_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StLoadCb;
                    cb_cnt_d  = '0;
                    pix_cnt_d = '0;
                end
            end
            StLoadCb: begin
                if (cb_valid) begin
                    cb_cnt_d = cb_cnt_q + CB_AW'(1);
                    if (cb_cnt_q == CbLast) begin
                        state_d = StDecode;
                    end
                end
            end
            StDecode: begin
                if (!stall) begin
                    pix_cnt_d = pix_cnt_q + PIX_AW'(1);
                    if (pix_cnt_q == PixLast) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= StIdle;
            cb_cnt_q       <= '0;
            pix_cnt_q      <= '0;
            weight_en      <= 1'b0;
            weight_data    <= '0;
            weight_A       <= '0;
            tag_en         <= 1'b0;
            RAM3_A_reg_out <= '0;
        end else begin
            state_q        <= state_d;
            cb_cnt_q       <= cb_cnt_d;
            pix_cnt_q      <= pix_cnt_d;
            weight_en      <= accept;
            if (accept) begin
                weight_data <= cb_data;
                weight_A    <= cb_cnt_q;
            end
            tag_en         <= idx_re;
            RAM3_A_reg_out <= idx_A;
        end
    end

endmodule

// File: tb/tb_decomp_addr_ctrl.sv
// Randomized self-checking bench for decomp_addr_ctrl with a cycle-level behavioural model.
// Build with DECOMP_PAUSE_EN defined to exercise the pause input as well.
module tb_decomp_addr_ctrl;

    localparam int PN = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic        cb_valid = 1'b0;
    logic [23:0] cb_data = '0;
    logic [5:0]  idx_data = '0;
    logic        cb_ready, idx_re, weight_en, tag_en, RAM3_WE_reg_out, done;
    logic [19:0] idx_A, RAM3_A_reg_out;
    logic [23:0] weight_data;
    logic [5:0]  weight_A, tag_A;
    logic [1:0]  state;

    decomp_addr_ctrl #(
        .DATA_W (24),
        .CB_AW  (6),
        .PIX_AW (20),
        .PIX_NUM(PN)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
`ifdef DECOMP_PAUSE_EN
        .pause          (pause),
`endif
        .cb_valid       (cb_valid),
        .cb_data        (cb_data),
        .cb_ready       (cb_ready),
        .idx_re         (idx_re),
        .idx_A          (idx_A),
        .idx_data       (idx_data),
        .weight_en      (weight_en),
        .weight_data    (weight_data),
        .weight_A       (weight_A),
        .tag_en         (tag_en),
        .tag_A          (tag_A),
        .RAM3_WE_reg_out(RAM3_WE_reg_out),
        .RAM3_A_reg_out (RAM3_A_reg_out),
        .state          (state),
        .done           (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 idle, 1 loading, 2 decoding, 3 done.
    int          m_phase = 0;
    int          m_cb = 0;
    int          m_pix = 0;
    logic        m_wen = 1'b0;
    logic [23:0] m_wd = '0;
    logic [5:0]  m_wa = '0;
    logic        m_ten = 1'b0;
    logic [19:0] m_ra = '0;
    logic [5:0]  idx_mem [PN];
    logic        pause_eff;
    logic        m_rd;

`ifdef DECOMP_PAUSE_EN
    assign pause_eff = pause;
`else
    assign pause_eff = 1'b0;
`endif
    assign m_rd = (m_phase == 2) && !pause_eff;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase <= 0;
            m_cb    <= 0;
            m_pix   <= 0;
            m_wen   <= 1'b0;
            m_wd    <= '0;
            m_wa    <= '0;
            m_ten   <= 1'b0;
            m_ra    <= '0;
        end else begin
            m_ten <= m_rd;
            m_ra  <= 20'(m_pix);
            m_wen <= (m_phase == 1) && cb_valid;
            case (m_phase)
                0: if (start) begin
                    m_phase <= 1;
                    m_cb    <= 0;
                    m_pix   <= 0;
                end
                1: if (cb_valid) begin
                    m_wd <= cb_data;
                    m_wa <= 6'(m_cb);
                    m_cb <= (m_cb + 1) % 64;
                    if (m_cb == 63) m_phase <= 2;
                end
                2: if (m_rd) begin
                    m_pix <= m_pix + 1;
                    if (m_pix == PN - 1) m_phase <= 3;
                end
                default: m_phase <= 0;
            endcase
        end
    end

    // Index memory: answers one cycle after a read with the addressed entry, junk otherwise.
    logic        re_s = 1'b0;
    logic [19:0] a_s = '0;
    always @(negedge clk) begin
        re_s = idx_re;
        a_s  = idx_A;
    end
    always @(posedge clk) begin
        #1;
        idx_data = re_s ? idx_mem[a_s[3:0]] : 6'($urandom);
    end

    int n_wr = 0, n_pix = 0, n_done = 0, n_dec = 0;
    bit dir_mode = 1'b0;

    always @(negedge clk) begin
        check("state", 32'(state), 32'(m_phase));
        check("cb_ready", 32'(cb_ready), 32'(m_phase == 1));
        check("idx_re", 32'(idx_re), 32'(m_rd));
        check("idx_A", 32'(idx_A), 32'(m_pix));
        check("weight_en", 32'(weight_en), 32'(m_wen));
        check("weight_data", 32'(weight_data), 32'(m_wd));
        check("weight_A", 32'(weight_A), 32'(m_wa));
        check("tag_en", 32'(tag_en), 32'(m_ten));
        check("RAM3_WE", 32'(RAM3_WE_reg_out), 32'(m_ten));
        check("RAM3_A", 32'(RAM3_A_reg_out), 32'(m_ra));
        check("tag_A", 32'(tag_A), m_ten ? 32'(idx_mem[m_ra[3:0]]) : 32'd0);
        check("done", 32'(done), 32'(m_phase == 3));
        if (rst) begin
            if (weight_en) begin
                check("wr_seq", 32'(weight_A), 32'(n_wr % 64));
                n_wr++;
            end
            if (RAM3_WE_reg_out) begin
                check("pix_seq", 32'(RAM3_A_reg_out), 32'(n_pix));
                if (dir_mode) check("tag_xor", 32'(tag_A), 32'(RAM3_A_reg_out[5:0] ^ 6'h2A));
                n_pix++;
            end
            if (state == 2'd2) n_dec++;
            if (done) n_done++;
        end
    end

    // pmode: 0 no pause, 1 pause in DECODE cycles 3-5, 2 random pause in any state.
    task automatic run_job(input int dens, input bit directed, input int pmode, input int abort);
        int n_acc = 0;
        int np = 0;
        int dc = 0;
        int cyc = 0;
        bit acc;
        for (int i = 0; i < PN; i++) begin
            idx_mem[i] = directed ? (6'(i) ^ 6'h2A) : 6'($urandom);
        end
        dir_mode = directed;
        n_wr = 0;
        n_pix = 0;
        n_done = 0;
        n_dec = 0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        while (cyc < 3000) begin
            if (abort > 0 && n_acc == abort) begin
                rst = 1'b0;
                #1;
                check("abort_state", 32'(state), 32'd0);
                check("abort_weight_en", 32'(weight_en), 32'd0);
                check("abort_weight_A", 32'(weight_A), 32'd0);
                check("abort_cb_ready", 32'(cb_ready), 32'd0);
                @(posedge clk);
                #1;
                rst = 1'b1;
                return;
            end
            cb_valid = ($urandom_range(99) < dens);
            cb_data  = directed ? 24'(n_acc * 32'h010101) : 24'($urandom);
            case (pmode)
                1:       pause = (m_phase == 2) && (dc >= 2) && (dc <= 4);
                2:       pause = ($urandom_range(2) == 0);
                default: pause = 1'b0;
            endcase
            start = (m_phase == 2) && ($urandom_range(3) == 0);
`ifdef DECOMP_PAUSE_EN
            if (pause && m_phase == 2) np++;
`endif
            if (m_phase == 2) dc++;
            acc = cb_valid && (m_phase == 1);
            @(posedge clk);
            #1;
            cyc++;
            if (acc) n_acc++;
            if (m_phase == 0) break;
        end
        start = 1'b0;
        cb_valid = 1'b0;
        pause = 1'b0;
        if (m_phase != 0) check("job_timeout", 32'd0, 32'd1);
        check("n_writes", 32'(n_wr), 32'd64);
        check("n_pixels", 32'(n_pix), 32'(PN));
        check("n_done", 32'(n_done), 32'd1);
        check("n_decode_cycles", 32'(n_dec), 32'(PN + np));
        if (pmode == 1) begin
`ifdef DECOMP_PAUSE_EN
            check("paused_decode_len", 32'(n_dec), 32'(PN + 3));
`else
            check("paused_decode_len", 32'(n_dec), 32'(PN));
`endif
        end
    endtask

    initial begin
        for (int i = 0; i < PN; i++) idx_mem[i] = '0;
        #2;
        rst = 1'b0;
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_idx_re", 32'(idx_re), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_tag_en", 32'(tag_en), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        run_job(100, 1'b1, 0, 0);
        run_job(100, 1'b0, 0, 10);
        run_job(100, 1'b1, 1, 0);
        run_job(50, 1'b0, 0, 0);
        for (int j = 0; j < 3; j++) begin
            run_job(30 + 30 * j, 1'b0, 2, 0);
        end
        repeat (3) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
